// File: rtl/dmem_responder.sv
// dmem_responder
//   Word-addressed data-memory responder for the processor load/store port.
//   Accepts one request at a time (req/ready), waits LATENCY cycles, performs
//   the read or write, then holds the result until the rvalid/rready handshake.
//
// Parameters
//   DEPTH   number of 32-bit words (word index 0..DEPTH-1)
//   LATENCY wait states between acceptance and access (0..15)
//
// Ports
//   clk     clock, rising edge
//   reset   asynchronous reset, active low
//   req     request valid            ready   responder can accept (registered)
//   we      1 = store, 0 = load      a       byte address
//   wd      store data
//   rvalid  response valid           rready  processor accepts response
//   rd      load data (0 for stores and errors)
//   err     bad access flag, meaningful while rvalid = 1

`timescale 1ns/1ps

module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    output logic        ready,
    input  logic        we,
    input  logic [31:0] a,
    input  logic [31:0] wd,
    output logic        rvalid,
    input  logic        rready,
    output logic [31:0] rd,
    output logic        err
);

    localparam int IDXW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_a;
    logic [31:0] r_wd;
    logic        r_ready;
    logic        r_rvalid;
    logic [31:0] r_rd;
    logic        r_err;

    // RAM contents are deliberately not reset.
    logic [31:0] r_mem [DEPTH];

    logic            w_accept;
    logic            w_access;
    logic            w_we;
    logic [31:0]     w_a;
    logic [31:0]     w_wd;
    logic            w_bad;
    logic [IDXW-1:0] w_idx;

    assign w_accept = (r_state == IDLE) && req;

    // With zero wait states the access happens on the accept edge itself,
    // so it must use the live inputs rather than the latched copies.
    always_comb begin
        if (LATENCY == 0) begin
            w_we     = we;
            w_a      = a;
            w_wd     = wd;
            w_access = w_accept;
        end else begin
            w_we     = r_we;
            w_a      = r_a;
            w_wd     = r_wd;
            w_access = (r_state == WAIT) && (r_cnt == 4'd0);
        end
    end

    assign w_bad = (w_a[1:0] != 2'b00) || (w_a[31:2] >= 30'(DEPTH));
    assign w_idx = w_a[IDXW+1:2];

    // Gated by reset so a request presented during reset never writes.
    always_ff @(posedge clk) begin
        if (reset && w_access && w_we && !w_bad) begin
            r_mem[w_idx] <= w_wd;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_we     <= 1'b0;
            r_a      <= '0;
            r_wd     <= '0;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_rd     <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we    <= we;
                r_a     <= a;
                r_wd    <= wd;
                r_ready <= 1'b0;
            end

            if (w_access) begin
                // Load data is the RAM value before any same-edge write.
                r_state  <= RESP;
                r_rvalid <= 1'b1;
                r_err    <= w_bad;
                r_rd     <= (w_bad || w_we) ? '0 : r_mem[w_idx];
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_accept) begin
                            r_state <= WAIT;
                            r_cnt   <= 4'(LATENCY - 1);
                        end
                    end
                    WAIT: begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                    RESP: begin
                        if (rready) begin
                            r_state  <= IDLE;
                            r_rvalid <= 1'b0;
                            r_rd     <= '0;
                            r_err    <= 1'b0;
                            r_ready  <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    assign ready  = r_ready;
    assign rvalid = r_rvalid;
    assign rd     = r_rd;
    assign err    = r_err;

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Word-addressed data-memory responder on the far side of the processor's load/store port. It accepts one request at a time over a req/ready handshake, inserts a programmable number of wait states, performs the read or write, and returns the result over an rvalid/rready handshake. It replaces the zero-latency data memory when the multicycle core is integrated, and it is also used as a slow-memory model in bench tests of that core.

## Interface
- DEPTH, 64: number of 32-bit words; legal word index 0..DEPTH-1.
- LATENCY, 2: wait states between acceptance and access; legal range 0..15.
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  1  request valid from the processor.
- ready  output  1  responder can accept a request this cycle.
- we  input  1  1 = store (MemWrite), 0 = load.
- a  input  32  byte address (DataAdr).
- wd  input  32  store data (WriteData).
- rvalid  output  1  response valid.
- rready  input  1  processor accepts the response.
- rd  output  32  load data (ReadData); 0 for stores and errors.
- err  output  1  response flags a bad access; valid only while rvalid = 1.

## Operation
- FSM states: IDLE, WAIT, RESP. Reset state is IDLE.
- Outputs during reset: ready = 1, rvalid = 0, rd = 0, err = 0. RAM contents are not reset.
- IDLE: ready = 1. When req & ready is sampled at an edge (accept edge), latch we, a and wd.
  - LATENCY = 0: go to RESP and perform the access on the accept edge.
  - LATENCY > 0: go to WAIT and load the 4-bit down-counter with LATENCY-1.
- WAIT: ready = 0; req is ignored. The counter decrements every cycle. When the counter is 0, go to RESP on the next edge and perform the access on that edge.
- Access, using latched values (or live inputs when LATENCY = 0):
  - Word index = a[31:2].
  - Bad access: a[1:0] != 0 or a[31:2] >= DEPTH. No RAM write; rd <= 0; err <= 1.
  - Good store: RAM[index] <= wd; rd <= 0; err <= 0.
  - Good load: rd <= RAM[index] (the value before any same-edge write); err <= 0.
- RESP: rvalid = 1, ready = 0. rd and err are held stable until the handshake. When rvalid & rready is sampled, go to IDLE, and rd and err return to 0.
- A new request is never accepted in the same cycle as a response handshake. ready rises only in the cycle after the handshake.
- Reset asserted mid-operation: the block returns to IDLE immediately.
  - In WAIT, the pending store is discarded and RAM is unchanged.
  - In RESP, the store has already been committed and the response is dropped.
- Inputs we, a and wd are don't-care outside the accept edge.

## Timing
- Accept edge E0. rvalid goes high in the cycle following edge E0+LATENCY. This gives LATENCY+1 cycles from the cycle req is sampled to first rvalid.
- Store commit edge = E0+LATENCY.
- Minimum request-to-request spacing: LATENCY+2 cycles, when rready is held at 1.
- rvalid stays high indefinitely while rready = 0. There is no timeout.
- ready is a registered decode of the state and has no combinational path from req. rvalid, rd and err are registered.

## Test plan
- Reset: hold reset = 0 for 3 cycles, then release. Check ready = 1, rvalid = 0, rd = 0, err = 0 in every cycle of reset.
- Store then load, LATENCY = 2, rready = 1:
  - Store a = 100, wd = 7. rvalid appears 3 cycles after the req cycle with err = 0 and rd = 0.
  - Then load a = 100. rd = 7 with the same latency.
- LATENCY = 0: store a = 96, wd = 0xDEADBEEF, then load a = 96. Each rvalid comes exactly 1 cycle after its accept, and the load returns 0xDEADBEEF.
- Backpressure:
  - Load with rready = 0 for 5 cycles. rvalid and rd stay stable, and ready stays 0 while req is held at 1.
  - Assert rready. rvalid drops next cycle, then ready = 1.
- Errors:
  - Load a = 101 (misaligned) gives err = 1, rd = 0.
  - Store a = 4*DEPTH, wd = 5 gives err = 1.
  - A later load of word 0 returns its prior value, unchanged.
- Reset mid-WAIT, LATENCY = 4:
  - Pre-store a = 8, wd = 1.
  - Issue store a = 8, wd = 9 and assert reset 2 cycles after accept.
  - After release, load a = 8 returns 1.
